query_scheduler: RTL and testbench
==================================

Name: query_scheduler

Overview:
Time-shares the single Collatz query engine among NUM_REQ requesters. Each requester gets a one-cycle ready pulse when its query is accepted, and later a one-cycle response carrying the cycle count and a status.
- Grants are round-robin; the pointer is re-anchored to requester 0 on every slot tick.
- Zero-valued queries are rejected without using the engine, because the engine never terminates on 0.
- Runaway queries (width overflow wraps the engine to 0) are timed out, and the engine is flushed back to idle before the next grant.
The block sits between the requesters and the engine's iQueryDataEn/iQueryData/oQueryEnd ports, and is fed by the engine's oSlotTick.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
BW_QUERY_DATA, 4, query/engine data width
BW_STEP, 8, width of step count; TIMEOUT < 2**BW_STEP
TIMEOUT, 64, max WAIT cycles before abort (>=2)

Ports:
iClk  in  1  clock
iRsn  in  1  async active-low reset
iSlotTick  in  1  slot tick from engine
iReqValid  in  NUM_REQ  per-requester query valid; held until ready
iReqData  in  NUM_REQ*BW_QUERY_DATA  per-requester query, requester k at bits [k*BW+:BW]
oReqReady  out  NUM_REQ  one-hot accept pulse
oRspValid  out  1  response pulse
oRspId  out  clog2(NUM_REQ)  requester id of the response
oRspSteps  out  BW_STEP  measured WAIT cycles
oRspStatus  out  2  0=OK, 1=ZERO_REJECT, 2=TIMEOUT
oQueryDataEn  out  1  engine load strobe
oQueryData  out  BW_QUERY_DATA  engine load value
iQueryEnd  in  1  engine oQueryEnd
oBusy  out  1  state != IDLE

Behaviour:
- Reset (async, iRsn=0): state IDLE, pointer 0, all outputs 0.
- All outputs are registered; response fields hold their values until the next response.
- FSM states: IDLE, ISSUE, WAIT, FLUSH, FLUSH_WAIT, RESP.
- IDLE:
  - If any iReqValid is set, pick the first valid requester searching from the pointer, wrapping.
  - Register the grant id and its data, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (1 cycle):
  - oReqReady[id]=1.
  - Pointer becomes id+1 mod NUM_REQ.
  - If data==0: no engine strobe, steps=0, status ZERO_REJECT, go to RESP.
  - Else: oQueryDataEn=1, oQueryData=data, clear step counter, go to WAIT.
- WAIT:
  - Each cycle with iQueryEnd=0, increment the counter.
  - iQueryEnd=1: status OK, steps=counter, go to RESP.
  - counter==TIMEOUT-1 with iQueryEnd=0: go to FLUSH.
- FLUSH (1 cycle):
  - oQueryDataEn=1, oQueryData=1.
  - Clear a 3-bit guard counter, go to FLUSH_WAIT.
- FLUSH_WAIT:
  - On iQueryEnd=1, or when the guard reaches 4, go to RESP with status TIMEOUT and steps=TIMEOUT.
- RESP (1 cycle): oRspValid=1 with oRspId, oRspSteps, oRspStatus; then go to IDLE.
  - This cycle covers the engine's clear-to-0 after its end pulse.
- Slot tick:
  - iSlotTick=1 sets the pointer to 0 in any state.
  - If it coincides with the ISSUE pointer update, the tick wins (pointer=0).
- Engine interaction:
  - At most one outstanding engine query.
  - oQueryDataEn is never asserted outside ISSUE and FLUSH.
  - iQueryEnd outside WAIT and FLUSH_WAIT is ignored.
- Requester rules:
  - Deasserting iReqValid before ready is legal; that requester is not granted, because selection is sampled in IDLE only.
  - Data is captured in IDLE.
- Latency: minimum issue-to-next-issue is 5 cycles for OK, and 3 for ZERO_REJECT.
- Throughput: one query in flight at a time.

Test Plan:
- Reset mid-WAIT (iRsn low 1 cycle):
  - All outputs go to 0 and the state returns to IDLE.
  - After release, a query of 4 completes with status OK and steps 2.
- Single requester 0, data 4:
  - oReqReady=0001 for one cycle; oQueryDataEn with 4 in the same cycle.
  - iQueryEnd arrives 3 cycles later; oRspValid follows with id 0, steps 2, status 0.
- Single query, data 1 (and separately data 2):
  - Response steps 1, status OK.
- Requester 2, data 0:
  - Ready pulse, no oQueryDataEn.
  - RESP arrives 1 cycle later with status 1, steps 0.
- Data 3 with BW_QUERY_DATA=4:
  - The engine wraps to 0 at 3*5+1 and never ends.
  - After TIMEOUT cycles, the FLUSH strobe loads 1, then iQueryEnd.
  - Response status 2, steps 64.
  - A following query of 4 returns steps 2.
- All 4 requesters valid with data 4 continuously:
  - Grant order 0,1,2,3,0.
  - iSlotTick pulsed during requester 1's WAIT makes the next grant 0, not 2.

Source files
------------

// File: rtl/query_scheduler.sv
// query_scheduler
// Time-shares a single Collatz query engine among NUM_REQ requesters.
// Requesters are granted round-robin. The grant pointer is pulled back to
// requester 0 on every engine slot tick. Zero-valued queries are answered
// without touching the engine. Runaway queries are timed out, and the engine
// is flushed with a known terminating value before the next grant.

module query_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int BW_QUERY_DATA = 4,
  parameter int BW_STEP       = 8,
  parameter int TIMEOUT       = 64
) (
  input  logic                             iClk,
  input  logic                             iRsn,
  input  logic                             iSlotTick,
  input  logic [NUM_REQ-1:0]               iReqValid,
  input  logic [NUM_REQ*BW_QUERY_DATA-1:0] iReqData,
  output logic [NUM_REQ-1:0]               oReqReady,
  output logic                             oRspValid,
  output logic [$clog2(NUM_REQ)-1:0]       oRspId,
  output logic [BW_STEP-1:0]               oRspSteps,
  output logic [1:0]                       oRspStatus,
  output logic                             oQueryDataEn,
  output logic [BW_QUERY_DATA-1:0]         oQueryData,
  input  logic                             iQueryEnd,
  output logic                             oBusy
);

  localparam int ID_W = $clog2(NUM_REQ);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_ISSUE      = 3'd1;
  localparam logic [2:0] ST_WAIT       = 3'd2;
  localparam logic [2:0] ST_FLUSH      = 3'd3;
  localparam logic [2:0] ST_FLUSH_WAIT = 3'd4;
  localparam logic [2:0] ST_RESP       = 3'd5;

  localparam logic [1:0] STATUS_OK          = 2'd0;
  localparam logic [1:0] STATUS_ZERO_REJECT = 2'd1;
  localparam logic [1:0] STATUS_TIMEOUT     = 2'd2;

  localparam logic [2:0] GUARD_LIMIT = 3'd4;

  logic [2:0]               state;
  logic [2:0]               stateNext;
  logic [ID_W-1:0]          pointer;
  logic [ID_W-1:0]          pointerNext;
  logic [ID_W-1:0]          grantId;
  logic [ID_W-1:0]          grantIdNext;
  logic [BW_QUERY_DATA-1:0] grantData;
  logic [BW_QUERY_DATA-1:0] grantDataNext;
  logic [BW_STEP-1:0]       stepCnt;
  logic [BW_STEP-1:0]       stepCntNext;
  logic [2:0]               guardCnt;
  logic [2:0]               guardCntNext;

  logic [ID_W-1:0]          rspIdNext;
  logic [BW_STEP-1:0]       rspStepsNext;
  logic [1:0]               rspStatusNext;
  logic [NUM_REQ-1:0]       readyNext;
  logic                     dataEnNext;
  logic [BW_QUERY_DATA-1:0] dataNext;

  logic                     pickValid;
  logic [ID_W-1:0]          pickId;
  int                       candIdx;

  logic [BW_QUERY_DATA-1:0] reqData [NUM_REQ];

  // Split the flat request data bus into one word per requester
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      reqData[k] = iReqData[k*BW_QUERY_DATA +: BW_QUERY_DATA];
    end
  end

  // Round-robin pick: scan backwards so the valid requester closest after the pointer wins
  always_comb begin
    pickValid = 1'b0;
    pickId    = '0;
    candIdx   = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      candIdx = (int'(pointer) + i) % NUM_REQ;
      if (iReqValid[ID_W'(candIdx)]) begin
        pickValid = 1'b1;
        pickId    = ID_W'(candIdx);
      end
    end
  end

  // Next-state logic for the FSM, the counters, the pointer and the response fields
  always_comb begin
    stateNext     = state;
    pointerNext   = pointer;
    grantIdNext   = grantId;
    grantDataNext = grantData;
    stepCntNext   = stepCnt;
    guardCntNext  = guardCnt;
    rspIdNext     = oRspId;
    rspStepsNext  = oRspSteps;
    rspStatusNext = oRspStatus;

    case (state)
      ST_IDLE: begin
        if (pickValid) begin
          grantIdNext   = pickId;
          grantDataNext = reqData[pickId];
          stateNext     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (grantId == ID_W'(NUM_REQ - 1)) begin
          pointerNext = '0;
        end else begin
          pointerNext = grantId + ID_W'(1);
        end
        if (grantData == '0) begin
          rspIdNext     = grantId;
          rspStepsNext  = '0;
          rspStatusNext = STATUS_ZERO_REJECT;
          stateNext     = ST_RESP;
        end else begin
          stepCntNext = '0;
          stateNext   = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (iQueryEnd) begin
          rspIdNext     = grantId;
          rspStepsNext  = stepCnt;
          rspStatusNext = STATUS_OK;
          stateNext     = ST_RESP;
        end else if (stepCnt == BW_STEP'(TIMEOUT - 1)) begin
          stateNext = ST_FLUSH;
        end else begin
          stepCntNext = stepCnt + BW_STEP'(1);
        end
      end

      ST_FLUSH: begin
        guardCntNext = '0;
        stateNext    = ST_FLUSH_WAIT;
      end

      ST_FLUSH_WAIT: begin
        if (iQueryEnd || (guardCnt == GUARD_LIMIT)) begin
          rspIdNext     = grantId;
          rspStepsNext  = BW_STEP'(TIMEOUT);
          rspStatusNext = STATUS_TIMEOUT;
          stateNext     = ST_RESP;
        end else begin
          guardCntNext = guardCnt + 3'd1;
        end
      end

      ST_RESP: begin
        stateNext = ST_IDLE;
      end

      default: begin
        stateNext = ST_IDLE;
      end
    endcase

    if (iSlotTick) begin
      pointerNext = '0;
    end
  end

  // Registered outputs are derived from the state being entered, so they line up with that state
  always_comb begin
    readyNext  = '0;
    dataEnNext = 1'b0;
    dataNext   = '0;
    if (stateNext == ST_ISSUE) begin
      readyNext  = NUM_REQ'(1) << grantIdNext;
      dataEnNext = (grantDataNext != '0);
      dataNext   = grantDataNext;
    end else if (stateNext == ST_FLUSH) begin
      dataEnNext = 1'b1;
      dataNext   = BW_QUERY_DATA'(1);
    end
  end

  // State, counters and every output register, cleared by the asynchronous reset
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state        <= ST_IDLE;
      pointer      <= '0;
      grantId      <= '0;
      grantData    <= '0;
      stepCnt      <= '0;
      guardCnt     <= '0;
      oReqReady    <= '0;
      oRspValid    <= 1'b0;
      oRspId       <= '0;
      oRspSteps    <= '0;
      oRspStatus   <= '0;
      oQueryDataEn <= 1'b0;
      oQueryData   <= '0;
      oBusy        <= 1'b0;
    end else begin
      state        <= stateNext;
      pointer      <= pointerNext;
      grantId      <= grantIdNext;
      grantData    <= grantDataNext;
      stepCnt      <= stepCntNext;
      guardCnt     <= guardCntNext;
      oReqReady    <= readyNext;
      oRspValid    <= (stateNext == ST_RESP);
      oRspId       <= rspIdNext;
      oRspSteps    <= rspStepsNext;
      oRspStatus   <= rspStatusNext;
      oQueryDataEn <= dataEnNext;
      oQueryData   <= dataNext;
      oBusy        <= (stateNext != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_query_scheduler.sv
// tb_query_scheduler
// Scoreboard bench for query_scheduler with a behavioural Collatz engine.
// Expected grants and responses are queued when stimulus is driven.
// A monitor pops and compares them whenever the scheduler produces output.

module tb_query_scheduler;

  localparam int NUM_REQ = 4;
  localparam int BW      = 4;
  localparam int BW_STEP = 8;
  localparam int TIMEOUT = 64;

  logic                  iClk;
  logic                  iRsn;
  logic                  iSlotTick;
  logic [NUM_REQ-1:0]    iReqValid;
  logic [NUM_REQ*BW-1:0] iReqData;
  logic [NUM_REQ-1:0]    oReqReady;
  logic                  oRspValid;
  logic [1:0]            oRspId;
  logic [BW_STEP-1:0]    oRspSteps;
  logic [1:0]            oRspStatus;
  logic                  oQueryDataEn;
  logic [BW-1:0]         oQueryData;
  logic                  iQueryEnd;
  logic                  oBusy;

  typedef struct {
    logic [1:0]         id;
    logic [BW_STEP-1:0] steps;
    logic [1:0]         status;
  } rsp_t;

  rsp_t rspQ[$];
  int   grantQ[$];
  int   checkCount;
  int   errorCount;

  logic [BW-1:0] engVal;
  logic          engBusy;
  logic          engFirst;

  query_scheduler #(
    .NUM_REQ      (NUM_REQ),
    .BW_QUERY_DATA(BW),
    .BW_STEP      (BW_STEP),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .iClk        (iClk),
    .iRsn        (iRsn),
    .iSlotTick   (iSlotTick),
    .iReqValid   (iReqValid),
    .iReqData    (iReqData),
    .oReqReady   (oReqReady),
    .oRspValid   (oRspValid),
    .oRspId      (oRspId),
    .oRspSteps   (oRspSteps),
    .oRspStatus  (oRspStatus),
    .oQueryDataEn(oQueryDataEn),
    .oQueryData  (oQueryData),
    .iQueryEnd   (iQueryEnd),
    .oBusy       (oBusy)
  );

  // Free-running clock
  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [BW-1:0] collatzNext(input logic [BW-1:0] v);
    if (v[0] == 1'b0) return v >> 1;
    return BW'(3 * v + 1);
  endfunction

  // Engine model: loads on the strobe, ends once its value is 1 after at least one step cycle
  assign iQueryEnd = engBusy && (engVal == BW'(1)) && !engFirst;

  initial begin
    engVal   = '0;
    engBusy  = 1'b0;
    engFirst = 1'b0;
  end

  // Engine model sequencing; after an end pulse it clears back to 0
  always @(posedge iClk) begin
    if (oQueryDataEn) begin
      engVal   <= oQueryData;
      engBusy  <= 1'b1;
      engFirst <= 1'b1;
    end else if (engBusy) begin
      if (iQueryEnd) begin
        engBusy <= 1'b0;
        engVal  <= '0;
      end else begin
        engFirst <= 1'b0;
        if (engVal != BW'(1)) engVal <= collatzNext(engVal);
      end
    end
  end

  // Monitor: compare each grant pulse and each response against the scoreboard
  always @(negedge iClk) begin
    if (oReqReady !== '0) begin
      if (grantQ.size() == 0) begin
        checkOutput("grantUnexpected", 32'(oReqReady), 32'd0);
      end else begin
        int expId;
        expId = grantQ.pop_front();
        checkOutput("grantOneHot", 32'(oReqReady), 32'd1 << expId);
      end
    end
    if (oRspValid === 1'b1) begin
      if (rspQ.size() == 0) begin
        checkOutput("rspUnexpected", 32'(oRspValid), 32'd0);
      end else begin
        rsp_t exp;
        exp = rspQ.pop_front();
        checkOutput("rspId", 32'(oRspId), 32'(exp.id));
        checkOutput("rspSteps", 32'(oRspSteps), 32'(exp.steps));
        checkOutput("rspStatus", 32'(oRspStatus), 32'(exp.status));
      end
    end
  end

  task automatic expectRsp(input int id, input int steps, input int status);
    rsp_t r;
    r.id     = 2'(id);
    r.steps  = BW_STEP'(steps);
    r.status = 2'(status);
    rspQ.push_back(r);
  endtask

  // Raise one requester, wait for its ready pulse and check the engine strobe in that cycle
  task automatic applyStimulus(input int id, input logic [BW-1:0] data, input bit pushRsp,
                               input int expSteps, input int expStatus);
    bit seen;
    seen = 1'b0;
    iReqData[id*BW +: BW] = data;
    iReqValid[id] = 1'b1;
    grantQ.push_back(id);
    if (pushRsp) expectRsp(id, expSteps, expStatus);
    for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
      @(posedge iClk); #1;
      if (oReqReady[id] === 1'b1) seen = 1'b1;
    end
    iReqValid[id] = 1'b0;
    checkOutput("readySeen", 32'(seen), 32'd1);
    checkOutput("strobeEn", 32'(oQueryDataEn), 32'(data != '0));
    checkOutput("strobeData", 32'(oQueryData), 32'(data));
  endtask

  task automatic waitDone(input string tag);
    bit done;
    done = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(posedge iClk); #2;
      if (rspQ.size() == 0 && grantQ.size() == 0 && oBusy === 1'b0) done = 1'b1;
    end
    checkOutput(tag, 32'(done), 32'd1);
  endtask

  task automatic anchorPointer();
    @(posedge iClk); #1;
    iSlotTick = 1'b1;
    @(posedge iClk); #1;
    iSlotTick = 1'b0;
  endtask

  // Hold a set of requesters valid until nGrants ready pulses; optionally tick tickDelay cycles after grant tickGrant
  task automatic runBurst(input logic [NUM_REQ-1:0] mask, input int nGrants,
                          input int tickGrant, input int tickDelay);
    int seen;
    int tickAt;
    seen   = 0;
    tickAt = -1;
    iReqValid = mask;
    for (int cyc = 0; cyc < 400 && seen < nGrants; cyc++) begin
      @(posedge iClk); #1;
      iSlotTick = (cyc == tickAt);
      if (oReqReady !== '0) begin
        seen++;
        if (seen == tickGrant) begin
          tickAt = cyc + tickDelay;
          if (tickDelay == 0) iSlotTick = 1'b1;
        end
        if (seen == nGrants) iReqValid = '0;
      end
    end
    iReqValid = '0;
    @(posedge iClk); #1;
    iSlotTick = 1'b0;
    checkOutput("burstGrants", 32'(seen), 32'(nGrants));
  endtask

  // Directed sequence following the test plan
  initial begin
    checkCount = 0;
    errorCount = 0;
    iRsn       = 1'b0;
    iSlotTick  = 1'b0;
    iReqValid  = '0;
    iReqData   = '0;

    repeat (3) @(posedge iClk);
    #1;
    checkOutput("resetReady", 32'(oReqReady), 32'd0);
    checkOutput("resetRspValid", 32'(oRspValid), 32'd0);
    checkOutput("resetRspFields", {24'd0, oRspId, oRspStatus, oRspSteps[3:0]}, 32'd0);
    checkOutput("resetStrobe", {27'd0, oQueryDataEn, oQueryData}, 32'd0);
    checkOutput("resetBusy", 32'(oBusy), 32'd0);
    iRsn = 1'b1;

    $display("[TB] single requester 0, data 4");
    applyStimulus(0, 4'd4, 1'b1, 2, 0);
    waitDone("doneData4");

    $display("[TB] data 1 and data 2");
    applyStimulus(1, 4'd1, 1'b1, 1, 0);
    waitDone("doneData1");
    applyStimulus(3, 4'd2, 1'b1, 1, 0);
    waitDone("doneData2");

    $display("[TB] zero reject on requester 2");
    applyStimulus(2, 4'd0, 1'b1, 0, 1);
    @(posedge iClk); #1;
    checkOutput("zeroRspNext", 32'(oRspValid), 32'd1);
    waitDone("doneZero");

    $display("[TB] runaway query 3 times out");
    applyStimulus(3, 4'd3, 1'b1, TIMEOUT, 2);
    waitDone("doneTimeout");
    applyStimulus(0, 4'd4, 1'b1, 2, 0);
    waitDone("doneAfterTimeout");

    $display("[TB] reset in the middle of WAIT");
    applyStimulus(1, 4'd8, 1'b0, 0, 0);
    @(posedge iClk); #1;
    @(posedge iClk); #1;
    checkOutput("busyInWait", 32'(oBusy), 32'd1);
    iRsn = 1'b0;
    #1;
    checkOutput("midResetBusy", 32'(oBusy), 32'd0);
    checkOutput("midResetSteps", 32'(oRspSteps), 32'd0);
    checkOutput("midResetStrobe", {27'd0, oQueryDataEn, oQueryData}, 32'd0);
    @(posedge iClk); #1;
    iRsn = 1'b1;
    repeat (6) @(posedge iClk);
    #1;
    checkOutput("idleAfterReset", 32'(oBusy), 32'd0);
    applyStimulus(0, 4'd4, 1'b1, 2, 0);
    waitDone("doneAfterReset");

    for (int k = 0; k < NUM_REQ; k++) iReqData[k*BW +: BW] = 4'd4;

    $display("[TB] round robin over all requesters");
    anchorPointer();
    for (int k = 0; k < 5; k++) begin
      grantQ.push_back(k % NUM_REQ);
      expectRsp(k % NUM_REQ, 2, 0);
    end
    runBurst(4'b1111, 5, 0, 0);
    waitDone("doneRoundRobin");

    $display("[TB] slot tick during requester 1 WAIT");
    anchorPointer();
    grantQ.push_back(0); expectRsp(0, 2, 0);
    grantQ.push_back(1); expectRsp(1, 2, 0);
    grantQ.push_back(0); expectRsp(0, 2, 0);
    runBurst(4'b1111, 3, 2, 1);
    waitDone("doneTickWait");

    $display("[TB] slot tick coinciding with the ISSUE pointer update");
    anchorPointer();
    grantQ.push_back(2); expectRsp(2, 2, 0);
    grantQ.push_back(2); expectRsp(2, 2, 0);
    runBurst(4'b1100, 2, 1, 0);
    waitDone("doneTickIssue");

    repeat (3) @(posedge iClk);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
